// File: rtl/fetch_unit_if.sv
// fetch_unit_if: control, ROM and IF/ID bundle between the fetch stage and its neighbours.
// Latency: none (wiring only).
// Backpressure: Stall/Flush and the redirect requests travel on this bundle.
interface fetch_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Stall;
    logic                  Flush;
    logic                  BranchTaken;
    logic [DATA_WIDTH-1:0] BranchTarget;
    logic                  Jump;
    logic [25:0]           JumpTarget;
    logic                  JumpReg;
    logic [DATA_WIDTH-1:0] RegTarget;
    logic [DATA_WIDTH-1:0] Instruction;
    logic [DATA_WIDTH-1:0] PCAddress;
    logic [DATA_WIDTH-1:0] IF_ID_Instruction;
    logic [DATA_WIDTH-1:0] IF_ID_PCPlus4;
    logic                  IF_ID_Valid;
    logic [DATA_WIDTH-1:0] FetchCount;
    logic                  MisalignedFault;

    modport master (
        output Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget,
               JumpReg, RegTarget, Instruction,
        input  PCAddress, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid,
               FetchCount, MisalignedFault
    );

    modport slave (
        input  Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget,
               JumpReg, RegTarget, Instruction,
        output PCAddress, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid,
               FetchCount, MisalignedFault
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: holds the PC, addresses the instruction ROM and registers the word into IF/ID.
// Latency: one edge from PC to IF_ID_*; any redirect costs one bubble on IF_ID_Valid.
// Backpressure: Stall holds PC and IF/ID, redirects still load PC; FETCH_ALIGN_CHECK_EN word-aligns jr targets and raises MisalignedFault.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h0040_0000)
) (
    input  logic        clk,
    input  logic        reset,
    fetch_unit_if.slave fif
);
    typedef enum logic {ST_RESET, ST_RUN} state_t;
    typedef enum logic [1:0] {ACT_SEQ, ACT_HOLD, ACT_REDIRECT} action_t;

    state_t                state;
    state_t                state_nxt;
    action_t               action;
    logic                  redirect;
    logic                  squash;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_nxt;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] jump_pc;
    logic [DATA_WIDTH-1:0] reg_pc;
    logic [DATA_WIDTH-1:0] ifid_ins;
    logic [DATA_WIDTH-1:0] ifid_p4;
    logic                  ifid_vld;
    logic [DATA_WIDTH-1:0] fetch_cnt;
    logic                  fault;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Pseudo-direct jumps take their region bits from the instruction that carried them.
    assign jump_pc  = {ifid_p4[DATA_WIDTH-1 -: 4], fif.JumpTarget, 2'b00};
    assign pc_plus4 = pc + DATA_WIDTH'(4);
    assign redirect = fif.JumpReg | fif.BranchTaken | fif.Jump;
    assign squash   = redirect | fif.Flush;

    always_comb begin
        state_nxt = ST_RUN;
        action    = ACT_SEQ;
        pc_nxt    = pc_plus4;
        unique case (state)
            ST_RESET: state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
        if (redirect) begin
            action = ACT_REDIRECT;
            if (fif.JumpReg) begin
                pc_nxt = reg_pc;
            end else if (fif.BranchTaken) begin
                pc_nxt = fif.BranchTarget;
            end else begin
                pc_nxt = jump_pc;
            end
        end else if (fif.Stall) begin
            action = ACT_HOLD;
            pc_nxt = pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            ifid_ins  <= '0;
            ifid_p4   <= '0;
            ifid_vld  <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            pc <= pc_nxt;
            if (squash) begin
                ifid_ins <= '0;
                ifid_p4  <= '0;
                ifid_vld <= 1'b0;
            end else if (action == ACT_SEQ) begin
                ifid_ins  <= fif.Instruction;
                ifid_p4   <= pc_plus4;
                ifid_vld  <= 1'b1;
                fetch_cnt <= fetch_cnt + DATA_WIDTH'(1);
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign reg_pc = {fif.RegTarget[DATA_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (fif.JumpReg && (fif.RegTarget[1:0] != 2'b00)) begin
            fault <= 1'b1;
        end
    end
`else
    assign reg_pc = fif.RegTarget;
    assign fault  = 1'b0;
`endif

    assign fif.PCAddress         = pc;
    assign fif.IF_ID_Instruction = ifid_ins;
    assign fif.IF_ID_PCPlus4     = ifid_p4;
    assign fif.IF_ID_Valid       = ifid_vld;
    assign fif.FetchCount        = fetch_cnt;
    assign fif.MisalignedFault   = fault;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors for fetch_unit; the driver queues hand-computed post-edge
// expectations and an independent monitor pops and compares them one edge later.
module tb_fetch_unit;
    logic clk;
    logic reset;

    fetch_unit_if #(.DATA_WIDTH(32)) fif();

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0040_0000)) u_dut (
        .clk   (clk),
        .reset (reset),
        .fif   (fif)
    );

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] p4;
        logic        vld;
        logic [31:0] cnt;
        logic        flt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic FLT = 1'b1;
`else
    localparam logic FLT = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0040_0000: rom = 32'h2008_0005;
            32'h0040_0004: rom = 32'h2009_0003;
            default:       rom = {16'h2400, a[15:0]};
        endcase
    endfunction

    always_comb fif.Instruction = rom(fif.PCAddress);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk($sformatf("v%0d_pc", e.id),  fif.PCAddress,               e.pc);
        chk($sformatf("v%0d_ins", e.id), fif.IF_ID_Instruction,       e.ins);
        chk($sformatf("v%0d_p4", e.id),  fif.IF_ID_PCPlus4,           e.p4);
        chk($sformatf("v%0d_vld", e.id), {31'd0, fif.IF_ID_Valid},    {31'd0, e.vld});
        chk($sformatf("v%0d_cnt", e.id), fif.FetchCount,              e.cnt);
        chk($sformatf("v%0d_flt", e.id), {31'd0, fif.MisalignedFault}, {31'd0, e.flt});
    endtask

    // Monitor: each expectation describes the outputs right after the following rising edge.
    initial begin
        exp_t e;
        n_cmp = 0;
        n_bad = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_all(e);
            end
        end
    end

    task automatic clear_inputs();
        fif.Stall        = 1'b0;
        fif.Flush        = 1'b0;
        fif.BranchTaken  = 1'b0;
        fif.BranchTarget = 32'h0;
        fif.Jump         = 1'b0;
        fif.JumpTarget   = 26'h0;
        fif.JumpReg      = 1'b0;
        fif.RegTarget    = 32'h0;
    endtask

    // Called at a falling edge: apply one cycle of inputs, queue the expectation, advance.
    task automatic step(input int id,
                        input logic st, input logic fl,
                        input logic br, input logic [31:0] btgt,
                        input logic jp, input logic [25:0] jtgt,
                        input logic jr, input logic [31:0] rtgt,
                        input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] p4, input logic vld,
                        input logic [31:0] cnt, input logic flt);
        exp_t e;
        fif.Stall        = st;
        fif.Flush        = fl;
        fif.BranchTaken  = br;
        fif.BranchTarget = btgt;
        fif.Jump         = jp;
        fif.JumpTarget   = jtgt;
        fif.JumpReg      = jr;
        fif.RegTarget    = rtgt;
        e.id  = id;
        e.pc  = pc;
        e.ins = ins;
        e.p4  = p4;
        e.vld = vld;
        e.cnt = cnt;
        e.flt = flt;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        exp_t r;
        int   budget;
        r.pc  = 32'h0040_0000;
        r.ins = 32'h0;
        r.p4  = 32'h0;
        r.vld = 1'b0;
        r.cnt = 32'h0;
        r.flt = 1'b0;

        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        r.id = 0;
        chk_all(r);
        reset = 1'b0;

        //    id st fl br btgt          jp jtgt         jr rtgt          pc            ins           p4            v  cnt
        step( 1, 0, 0, 0, 32'h0,        0, 26'h0,       0, 32'h0,        32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 1, 32'd1, 0);
        step( 2, 0, 0, 0, 32'h0,        0, 26'h0,       0, 32'h0,        32'h0040_0008, 32'h2009_0003, 32'h0040_0008, 1, 32'd2, 0);
        step( 3, 0, 0, 0, 32'h0,        0, 26'h0,       0, 32'h0,        32'h0040_000C, 32'h2400_0008, 32'h0040_000C, 1, 32'd3, 0);
        step( 4, 0, 0, 1, 32'h0040_0020, 0, 26'h0,      0, 32'h0,        32'h0040_0020, 32'h0,         32'h0,         0, 32'd3, 0);
        step( 5, 0, 0, 0, 32'h0,        0, 26'h0,       0, 32'h0,        32'h0040_0024, 32'h2400_0020, 32'h0040_0024, 1, 32'd4, 0);
        step( 6, 0, 0, 1, 32'h0040_000C, 0, 26'h0,      0, 32'h0,        32'h0040_000C, 32'h0,         32'h0,         0, 32'd4, 0);
        step( 7, 0, 0, 0, 32'h0,        0, 26'h0,       0, 32'h0,        32'h0040_0010, 32'h2400_000C, 32'h0040_0010, 1, 32'd5, 0);
        step( 8, 0, 0, 0, 32'h0,        1, 26'h010_0008, 0, 32'h0,       32'h0040_0020, 32'h0,         32'h0,         0, 32'd5, 0);
        step( 9, 0, 0, 1, 32'h0040_0080, 0, 26'h0,      1, 32'h0040_0040, 32'h0040_0040, 32'h0,        32'h0,         0, 32'd5, 0);
        step(10, 0, 0, 0, 32'h0,        0, 26'h0,       0, 32'h0,        32'h0040_0044, 32'h2400_0040, 32'h0040_0044, 1, 32'd6, 0);
        for (int i = 0; i < 3; i++) begin
            step(11 + i, 1, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0,
                 32'h0040_0044, 32'h2400_0040, 32'h0040_0044, 1, 32'd6, 0);
        end
        step(14, 1, 0, 0, 32'h0,        1, 26'h010_0030, 0, 32'h0,       32'h0040_00C0, 32'h0,         32'h0,         0, 32'd6, 0);
        step(15, 0, 0, 0, 32'h0,        0, 26'h0,       0, 32'h0,        32'h0040_00C4, 32'h2400_00C0, 32'h0040_00C4, 1, 32'd7, 0);
        step(16, 0, 1, 0, 32'h0,        0, 26'h0,       0, 32'h0,        32'h0040_00C8, 32'h0,         32'h0,         0, 32'd7, 0);
        step(17, 0, 0, 0, 32'h0,        0, 26'h0,       0, 32'h0,        32'h0040_00CC, 32'h2400_00C8, 32'h0040_00CC, 1, 32'd8, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        step(18, 0, 0, 0, 32'h0,        0, 26'h0,       1, 32'h0040_0006, 32'h0040_0004, 32'h0,        32'h0,         0, 32'd8, FLT);
        step(19, 0, 0, 0, 32'h0,        0, 26'h0,       0, 32'h0,        32'h0040_0008, 32'h2009_0003, 32'h0040_0008, 1, 32'd9, FLT);
`else
        step(18, 0, 0, 0, 32'h0,        0, 26'h0,       1, 32'h0040_0006, 32'h0040_0006, 32'h0,        32'h0,         0, 32'd8, FLT);
        step(19, 0, 0, 0, 32'h0,        0, 26'h0,       0, 32'h0,        32'h0040_000A, 32'h2400_0006, 32'h0040_000A, 1, 32'd9, FLT);
`endif
        step(20, 0, 0, 0, 32'h0,        0, 26'h0,       1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,        32'h0,         0, 32'd9, FLT);
        step(21, 0, 0, 0, 32'h0,        0, 26'h0,       0, 32'h0,        32'h0000_0000, 32'h2400_FFFC, 32'h0000_0000, 1, 32'd10, FLT);
        step(22, 0, 0, 0, 32'h0,        0, 26'h0,       0, 32'h0,        32'h0000_0004, 32'h2400_0000, 32'h0000_0004, 1, 32'd11, FLT);
        step(23, 1, 1, 0, 32'h0,        0, 26'h0,       0, 32'h0,        32'h0000_0004, 32'h0,         32'h0,         0, 32'd11, FLT);

        // Reset lands between edges while a stall and a branch are pending.
        fif.Stall        = 1'b1;
        fif.BranchTaken  = 1'b1;
        fif.BranchTarget = 32'h0040_0100;
        #2;
        reset = 1'b1;
        #1;
        r.id = 24;
        chk_all(r);
        @(posedge clk);
        #1;
        r.id = 25;
        chk_all(r);
        @(negedge clk);
        reset = 1'b0;
        step(26, 0, 0, 0, 32'h0,        0, 26'h0,       0, 32'h0,        32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 1, 32'd1, 0);
        clear_inputs();

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
